frame_buf: RTL and testbench

//  Ping-pong acquisition frame buffer feeding the UDP sender's read port (rd_addr/rd_data).

---
 rtl/frame_buf_pkg.sv | 24 ++
 rtl/frame_buf_ram.sv | 32 +++
 rtl/frame_buf.sv | 183 ++++++++++++++++++
 tb/tb_frame_buf.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/frame_buf_pkg.sv
// Shared constants and types for the ping-pong acquisition frame buffer.
// Optional feature macro: FRAME_BUF_TEST_PATTERN_EN (see frame_buf.sv).
package frame_buf_pkg;

    localparam int          ADDR_W     = 10;
    localparam int          HDR_WORDS  = 4;
    localparam logic [15:0] MAGIC      = 16'hA55A;
    localparam int          DATA_WORDS = (1 << ADDR_W) - HDR_WORDS;
    localparam int          HDR_IDX_W  = $clog2(HDR_WORDS);

    // Header word positions within the read window
    localparam int HDR_MAGIC = 0;
    localparam int HDR_TIME  = 1;
    localparam int HDR_COUNT = 2;
    localparam int HDR_DROP  = 3;

    // Source of the word presented on the read port one cycle after the address
    typedef enum logic [1:0] {
        RD_ZERO = 2'd0,
        RD_HDR  = 2'd1,
        RD_RAM  = 2'd2
    } rd_sel_e;

endpackage

// File: rtl/frame_buf_ram.sv
// Simple dual-port RAM holding both frame banks: synchronous write,
// registered read. Contents are intentionally not reset.
module frame_buf_ram #(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buf.sv
// Ping-pong acquisition frame buffer. Samples fill the write bank; each
// falling edge of msync_n swaps banks and publishes the filled bank with a
// 4-word header (magic/frame count, timestamp, word count + overflow, drops).
// Optional feature: define FRAME_BUF_TEST_PATTERN_EN to store the pattern
// {frame_cnt, wr_cnt[15:0]} instead of the incoming sample words.
module frame_buf
    import frame_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       i_wr_data,
    input  logic              i_wr_vld,
    input  logic              i_msync_n,
    input  logic [31:0]       i_ms_counter,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [31:0]       o_rd_data,
    output logic              o_frame_rdy,
    output logic [15:0]       o_frame_cnt
);

    localparam logic [ADDR_W-1:0] HDR_OFS  = ADDR_W'(HDR_WORDS);
    localparam logic [ADDR_W-1:0] DATA_LIM = ADDR_W'(DATA_WORDS);

    // Frame sync synchroniser and edge detector
    logic sync1_q, sync2_q, sync3_q;
    logic swap_s;

    // Write side state
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [31:0]       drop_cnt_q, drop_cnt_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              frame_rdy_q, frame_rdy_d;
    logic [31:0]       hdr_q [HDR_WORDS];
    logic [31:0]       hdr_d [HDR_WORDS];

    logic              wr_acc_s, wr_drop_s;
    logic [ADDR_W-1:0] cnt_fin_s;
    logic [31:0]       drop_fin_s;
    logic [31:0]       wr_word_s;
    logic [ADDR_W:0]   wr_addr_s;

    // Read side state
    rd_sel_e           rd_sel_q, rd_sel_d;
    logic [31:0]       rd_hdr_q, rd_hdr_d;
    logic [ADDR_W:0]   rd_addr_s;
    logic [31:0]       ram_rdata_s;
    logic [16:0]       rd_lim_s;

    // Two-flop synchroniser plus one delay stage for falling-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
        end else begin
            sync1_q <= i_msync_n;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign swap_s = sync3_q & ~sync2_q;

    // Accept/drop decision and final counts including this cycle's write
    always_comb begin
        wr_acc_s   = i_wr_vld && (wr_cnt_q < DATA_LIM);
        wr_drop_s  = i_wr_vld && !(wr_cnt_q < DATA_LIM);
        cnt_fin_s  = wr_cnt_q + ADDR_W'(wr_acc_s);
        if (wr_drop_s && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_fin_s = drop_cnt_q + 32'd1;
        end else begin
            drop_fin_s = drop_cnt_q;
        end
        wr_addr_s  = {wr_bank_q, wr_cnt_q + HDR_OFS};
`ifdef FRAME_BUF_TEST_PATTERN_EN
        wr_word_s  = {frame_cnt_q, 16'(wr_cnt_q)};
`else
        wr_word_s  = i_wr_data;
`endif
    end

    // Next-state for counters, bank flags and header registers
    always_comb begin
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_cnt_d    = cnt_fin_s;
        drop_cnt_d  = drop_fin_s;
        frame_cnt_d = frame_cnt_q;
        frame_rdy_d = 1'b0;
        hdr_d       = hdr_q;
        if (swap_s) begin
            wr_bank_d   = ~wr_bank_q;
            rd_bank_d   = ~rd_bank_q;
            wr_cnt_d    = {ADDR_W{1'b0}};
            drop_cnt_d  = 32'h0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            frame_rdy_d = 1'b1;
            hdr_d[HDR_MAGIC] = {MAGIC, frame_cnt_q + 16'd1};
            hdr_d[HDR_TIME]  = i_ms_counter;
            hdr_d[HDR_COUNT] = {(drop_fin_s != 32'h0), 15'h0, 16'(cnt_fin_s)};
            hdr_d[HDR_DROP]  = drop_fin_s;
        end else begin
            frame_rdy_d = 1'b0;
        end
    end

    // Frame state registers; reset discards any frame in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b1;
            wr_cnt_q    <= {ADDR_W{1'b0}};
            drop_cnt_q  <= 32'h0;
            frame_cnt_q <= 16'h0;
            frame_rdy_q <= 1'b0;
            for (int i = 0; i < HDR_WORDS; i++) begin
                hdr_q[i] <= 32'h0;
            end
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            frame_rdy_q <= frame_rdy_d;
            hdr_q       <= hdr_d;
        end
    end

    // Read decode: header, payload or zero, chosen with the address so bank
    // select and header values are taken from the same cycle
    always_comb begin
        rd_lim_s = 17'(HDR_OFS) + {1'b0, hdr_q[HDR_COUNT][15:0]};
        rd_addr_s = {rd_bank_q, i_rd_addr};
        rd_hdr_d = 32'h0;
        if (i_rd_addr < HDR_OFS) begin
            rd_sel_d = RD_HDR;
            rd_hdr_d = hdr_q[i_rd_addr[HDR_IDX_W-1:0]];
        end else if (17'(i_rd_addr) < rd_lim_s) begin
            rd_sel_d = RD_RAM;
        end else begin
            rd_sel_d = RD_ZERO;
        end
    end

    // Read pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel_q <= RD_ZERO;
            rd_hdr_q <= 32'h0;
        end else begin
            rd_sel_q <= rd_sel_d;
            rd_hdr_q <= rd_hdr_d;
        end
    end

    // Output select between registered header word and registered RAM data
    always_comb begin
        case (rd_sel_q)
            RD_HDR:  o_rd_data = rd_hdr_q;
            RD_RAM:  o_rd_data = ram_rdata_s;
            default: o_rd_data = 32'h0;
        endcase
    end

    frame_buf_ram #(
        .AW (ADDR_W + 1),
        .DW (32)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc_s),
        .waddr_i (wr_addr_s),
        .wdata_i (wr_word_s),
        .raddr_i (rd_addr_s),
        .rdata_o (ram_rdata_s)
    );

    assign o_frame_rdy = frame_rdy_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_frame_buf.sv
// Directed self-checking bench for frame_buf with a read-result scoreboard.
module tb_frame_buf;
    import frame_buf_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       wr_data;
    logic              wr_vld;
    logic              msync_n;
    logic [31:0]       ms_counter;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              frame_rdy;
    logic [15:0]       frame_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    frame_buf dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wr_data    (wr_data),
        .i_wr_vld     (wr_vld),
        .i_msync_n    (msync_n),
        .i_ms_counter (ms_counter),
        .i_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .o_frame_rdy  (frame_rdy),
        .o_frame_cnt  (frame_cnt)
    );

    function automatic logic [31:0] exp_data(input int fc, input int idx, input logic [31:0] d);
`ifdef FRAME_BUF_TEST_PATTERN_EN
        exp_data = {16'(fc), 16'(idx)};
`else
        exp_data = d;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one read; expected value goes to the scoreboard, popped when data returns
    task automatic rd(input string tag, input int a, input logic [31:0] e);
        rd_addr = ADDR_W'(a);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        check(tag, rd_data, exp_q.pop_front());
    endtask

    task automatic wr(input logic [31:0] d);
        wr_data = d;
        wr_vld  = 1'b1;
        @(negedge clk);
        wr_vld  = 1'b0;
    endtask

    // Pulse msync_n low and expect exactly one frame_rdy pulse within a bounded window
    task automatic swap(input logic [15:0] exp_fc);
        int pulses;
        pulses  = 0;
        msync_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (frame_rdy) pulses++;
        end
        msync_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (frame_rdy) pulses++;
        end
        check("frame_rdy_pulses", 32'(pulses), 32'd1);
        check("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        rst_n      = 1'b0;
        wr_data    = 32'h0;
        wr_vld     = 1'b0;
        msync_n    = 1'b1;
        ms_counter = 32'h0;
        rd_addr    = '0;
        repeat (3) @(negedge clk);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_frame_rdy", 32'(frame_rdy), 32'h0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: no stimulus, every address reads zero, no frame pulses
        pulses = 0;
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            rd("idle_read", a, 32'h0);
            if (frame_rdy) pulses++;
        end
        check("idle_no_rdy", 32'(pulses), 32'h0);
        check("idle_frame_cnt", 32'(frame_cnt), 32'h0);

        // 2: ten words, one swap
        for (int i = 0; i < 10; i++) wr(32'h100 + 32'(i));
        ms_counter = 32'h55;
        swap(16'd1);
        rd("t2_hdr0", 0, 32'hA55A_0001);
        rd("t2_hdr1", 1, 32'h0000_0055);
        rd("t2_hdr2", 2, 32'h0000_000A);
        rd("t2_hdr3", 3, 32'h0);
        for (int i = 0; i < 10; i++) rd("t2_data", 4 + i, exp_data(0, i, 32'h100 + 32'(i)));
        rd("t2_past_end", 14, 32'h0);

        // 3: overflow, 1025 words into a fresh frame
        do_reset();
        for (int i = 0; i < 1025; i++) wr(32'h3000 + 32'(i));
        ms_counter = 32'h1234_5678;
        swap(16'd1);
        rd("t3_hdr0", 0, 32'hA55A_0001);
        rd("t3_hdr1", 1, 32'h1234_5678);
        rd("t3_hdr2", 2, 32'h8000_03FC);
        rd("t3_hdr3", 3, 32'h0000_0005);
        rd("t3_first", 4, exp_data(0, 0, 32'h3000));
        rd("t3_last", 1023, exp_data(0, 1019, 32'h3000 + 32'd1019));

        // 4: write landing in the swap cycle belongs to the old frame
        wr(32'h11);
        wr(32'h22);
        msync_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wr_data = 32'hDEAD;
        wr_vld  = 1'b1;
        @(negedge clk);
        check("t4_rdy_after_swap", 32'(frame_rdy), 32'h1);
        wr_data = 32'hBEEF;
        @(negedge clk);
        wr_vld  = 1'b0;
        msync_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_frame_cnt", 32'(frame_cnt), 32'd2);
        rd("t4_hdr0", 0, 32'hA55A_0002);
        rd("t4_hdr2", 2, 32'h0000_0003);
        rd("t4_hdr3", 3, 32'h0);
        rd("t4_w0", 4, exp_data(1, 0, 32'h11));
        rd("t4_deadlast", 6, exp_data(1, 2, 32'hDEAD));
        rd("t4_past_end", 7, 32'h0);
        wr(32'h33);
        swap(16'd3);
        rd("t4n_hdr2", 2, 32'h0000_0002);
        rd("t4n_first", 4, exp_data(2, 0, 32'hBEEF));
        rd("t4n_second", 5, exp_data(2, 1, 32'h33));

        // 5: back-to-back frames, then reset mid-frame
        do_reset();
        for (int i = 0; i < 3; i++) wr(32'h500 + 32'(i));
        swap(16'd1);
        for (int i = 0; i < 5; i++) wr(32'h600 + 32'(i));
        swap(16'd2);
        rd("t5_hdr0", 0, 32'hA55A_0002);
        rd("t5_hdr2", 2, 32'h0000_0005);
        for (int i = 0; i < 5; i++) rd("t5_data", 4 + i, exp_data(1, i, 32'h600 + 32'(i)));
        rd("t5_past_end", 9, 32'h0);
        wr(32'h700);
        wr(32'h701);
        rst_n  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (frame_rdy) pulses++;
        end
        check("t5_rst_frame_cnt", 32'(frame_cnt), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (frame_rdy) pulses++;
        end
        check("t5_rst_no_rdy", 32'(pulses), 32'h0);
        rd("t5_rst_hdr0", 0, 32'h0);
        rd("t5_rst_hdr2", 2, 32'h0);
        rd("t5_rst_data", 4, 32'h0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
